// File: rtl/hamming_pkg.sv
// Shared constants for the SECDED Hamming(12,7) encoder and its decoder.
// Codeword positions are numbered 12..1; parity bits sit at the powers of two,
// data bits fill the remaining positions below 12, and position 12 carries
// the overall (even) parity.
package hamming_pkg;

   localparam int unsigned DATA_W = 7;
   localparam int unsigned CODE_W = 12;

   localparam int unsigned P1_POS      = 1;
   localparam int unsigned P2_POS      = 2;
   localparam int unsigned P4_POS      = 4;
   localparam int unsigned P8_POS      = 8;
   localparam int unsigned OVERALL_POS = 12;

   localparam int unsigned PARITY_POS [0:3] = '{P1_POS, P2_POS, P4_POS, P8_POS};

   // Codeword position of d1..d7.
   localparam int unsigned DATA_POS [1:DATA_W] = '{3, 5, 6, 7, 9, 10, 11};

endpackage

// File: rtl/hamming_encode_core.sv
// Combinational SECDED Hamming(12,7) encoder.
// Ports:
//   in_data  [7:1]  data word d7..d1
//   out_code [12:1] codeword: parity at 1,2,4,8, data at 3,5,6,7,9,10,11,
//                   overall even parity at 12
module hamming_encode_core
   import hamming_pkg::*;
(
   input  logic [DATA_W:1] in_data,
   output logic [CODE_W:1] out_code
);

   logic [CODE_W:1] w_code;
   logic            w_par;

   always_comb begin
      w_code = '0;
      w_par  = 1'b0;
      for (int i = 1; i <= int'(DATA_W); i++) begin
         w_code[4'(DATA_POS[3'(i)])] = in_data[3'(i)];
      end
      // Parity slots are still zero while their group is summed, and no
      // power-of-two position belongs to another group, so summing every
      // position in the group is equivalent to summing only the data bits.
      for (int k = 0; k < 4; k++) begin
         w_par = 1'b0;
         for (int pos = 1; pos <= 11; pos++) begin
            if (((pos >> k) & 1) == 1) begin
               w_par = w_par ^ w_code[4'(pos)];
            end
         end
         w_code[4'(PARITY_POS[2'(k)])] = w_par;
      end
      w_code[4'(OVERALL_POS)] = ^w_code;
   end

   assign out_code = w_code;

endmodule

// File: rtl/hamming_encode_stream.sv
// Streaming SECDED encoder with fault injection and a 2-entry output FIFO.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_data/in_valid/in_ready   upstream handshake, 7-bit data word
//   inject_mask                 bit-flip mask XORed into the stored codeword
//   out_code/out_valid/out_ready downstream handshake, 12-bit codeword
//   word_count                  accepted words (wrapping)
//   inject_count                accepted words with a nonzero mask (wrapping)
module hamming_encode_stream
   import hamming_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DATA_W:1]  in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CODE_W:1]  inject_mask,
   output logic [CODE_W:1]  out_code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] word_count,
   output logic [CNT_W-1:0] inject_count
);

   logic [CODE_W:1]  w_enc;
   logic             w_push;
   logic             w_pop;

   logic [CODE_W:1]  r_mem0;
   logic [CODE_W:1]  r_mem1;
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic [CNT_W-1:0] r_word_count;
   logic [CNT_W-1:0] r_inject_count;

   hamming_encode_core u_core (
      .in_data  (in_data),
      .out_code (w_enc)
   );

   // Handshake flags depend only on registered occupancy; out_ready never
   // reaches in_ready combinationally.
   assign in_ready  = (r_count != 2'd2);
   assign out_valid = (r_count != 2'd0);
   assign out_code  = r_rd_ptr ? r_mem1 : r_mem0;

   assign w_push = in_valid & in_ready;
   assign w_pop  = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mem0         <= '0;
         r_mem1         <= '0;
         r_wr_ptr       <= 1'b0;
         r_rd_ptr       <= 1'b0;
         r_count        <= 2'd0;
         r_word_count   <= '0;
         r_inject_count <= '0;
      end else begin
         if (w_push) begin
            if (r_wr_ptr) begin
               r_mem1 <= w_enc ^ inject_mask;
            end else begin
               r_mem0 <= w_enc ^ inject_mask;
            end
            r_wr_ptr     <= ~r_wr_ptr;
            r_word_count <= r_word_count + CNT_W'(1);
            if (inject_mask != '0) begin
               r_inject_count <= r_inject_count + CNT_W'(1);
            end
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign word_count   = r_word_count;
   assign inject_count = r_inject_count;

endmodule

// File: tb/tb_hamming_encode_stream.sv
module tb_hamming_encode_stream;

   logic        clk;
   logic        rst_n;
   logic [7:1]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [12:1] inject_mask;
   logic [12:1] out_code;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] word_count;
   logic [15:0] inject_count;

   // Narrow-counter instance for the wrap test.
   logic        c_rst_n;
   logic [7:1]  c_in_data;
   logic        c_in_valid;
   logic        c_in_ready;
   logic [12:1] c_inject_mask;
   logic [12:1] c_out_code;
   logic        c_out_valid;
   logic        c_out_ready;
   logic [3:0]  c_word_count;
   logic [3:0]  c_inject_count;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pops   = 0;
   int exp_q[$];
   int exp_words;
   int exp_inj;

   hamming_encode_stream dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .inject_mask  (inject_mask),
      .out_code     (out_code),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .word_count   (word_count),
      .inject_count (inject_count)
   );

   hamming_encode_stream #(.CNT_W(4)) dut_w4 (
      .clk          (clk),
      .rst_n        (c_rst_n),
      .in_data      (c_in_data),
      .in_valid     (c_in_valid),
      .in_ready     (c_in_ready),
      .inject_mask  (c_inject_mask),
      .out_code     (c_out_code),
      .out_valid    (c_out_valid),
      .out_ready    (c_out_ready),
      .word_count   (c_word_count),
      .inject_count (c_inject_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference encoder from the codeword rules, in plain integer arithmetic.
   function automatic int ref_encode(input int data);
      int dpos[7] = '{3, 5, 6, 7, 9, 10, 11};
      int code = 0;
      int par;
      for (int i = 0; i < 7; i++) begin
         if (((data >> i) & 1) == 1) code = code | (1 << (dpos[i] - 1));
      end
      for (int p = 1; p <= 8; p = p * 2) begin
         par = 0;
         for (int pos = 1; pos <= 11; pos++) begin
            if ((pos & p) != 0) par = par ^ ((code >> (pos - 1)) & 1);
         end
         if (par == 1) code = code | (1 << (p - 1));
      end
      par = 0;
      for (int pos = 1; pos <= 11; pos++) par = par ^ ((code >> (pos - 1)) & 1);
      if (par == 1) code = code | (1 << 11);
      return code;
   endfunction

   // Scoreboard: occupancy, head word and counters follow from the queue of
   // expected codewords; updated just before the edge that acts on them.
   task automatic monitor();
      if (!rst_n) begin
         exp_q.delete();
         exp_words = 0;
         exp_inj   = 0;
      end else begin
         check("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
         check("in_ready", {31'b0, in_ready}, {31'b0, exp_q.size() < 2});
         check("word_count", {16'b0, word_count}, exp_words & 32'hFFFF);
         check("inject_count", {16'b0, inject_count}, exp_inj & 32'hFFFF);
         if (exp_q.size() != 0) check("out_code_head", {20'b0, out_code}, exp_q[0]);
         if (out_valid && out_ready && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            n_pops++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_encode(int'(in_data)) ^ int'(inject_mask));
            exp_words++;
            if (inject_mask != 12'b0) exp_inj++;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic send_one(input logic [7:1] d, input logic [12:1] m, input logic [12:1] exp,
                           input string tag);
      in_data     = d;
      inject_mask = m;
      in_valid    = 1'b1;
      out_ready   = 1'b0;
      step();
      in_valid    = 1'b0;
      inject_mask = '0;
      check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
      check({tag, "_code"}, {20'b0, out_code}, {20'b0, exp});
   endtask

   task automatic pop_one();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      int syn;
      int par;
      logic [12:1] code_a;
      logic [12:1] code_b;
      logic [12:1] code_c;

      rst_n = 1'b0; in_data = '0; in_valid = 1'b0; inject_mask = '0; out_ready = 1'b0;
      c_rst_n = 1'b0; c_in_data = '0; c_in_valid = 1'b0; c_inject_mask = '0;
      c_out_ready = 1'b0;
      step();
      step();
      rst_n   = 1'b1;
      c_rst_n = 1'b1;

      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_out_code", {20'b0, out_code}, 32'd0);
      check("rst_word_count", {16'b0, word_count}, 32'd0);
      check("rst_inject_count", {16'b0, inject_count}, 32'd0);

      // Encoding cases.
      send_one(7'b0000001, 12'b0, 12'b100000000111, "enc_d1");
      pop_one();
      send_one(7'b1111111, 12'b0, 12'b111111111111, "enc_all1");
      pop_one();
      send_one(7'b0000000, 12'b0, 12'b000000000000, "enc_zero");
      pop_one();

      // Injection and syndrome of the corrupted word.
      send_one(7'b0000001, 12'b000000000100, 12'b100000000011, "inj");
      check("inj_count", {16'b0, inject_count}, 32'd1);
      syn = 0;
      par = 0;
      for (int pos = 1; pos <= 12; pos++) begin
         if (((int'(out_code) >> (pos - 1)) & 1) == 1) begin
            par = par ^ 1;
            if (pos <= 11) syn = syn ^ pos;
         end
      end
      check("inj_syndrome", syn, 32'd3);
      check("inj_single_error", par, 32'd1);
      pop_one();

      // Backpressure: three words, only two fit.
      code_a = 12'(ref_encode(7'h15));
      code_b = 12'(ref_encode(7'h2A));
      code_c = 12'(ref_encode(7'h63));
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 7'h15;
      step();
      in_data   = 7'h2A;
      step();
      in_data   = 7'h63;
      check("bp_ready_low", {31'b0, in_ready}, 32'd0);
      step();
      check("bp_still_low", {31'b0, in_ready}, 32'd0);
      check("bp_head_a", {20'b0, out_code}, {20'b0, code_a});
      out_ready = 1'b1;
      step();
      check("bp_drain_b", {20'b0, out_code}, {20'b0, code_b});
      check("bp_ready_back", {31'b0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      check("bp_drain_c", {20'b0, out_code}, {20'b0, code_c});
      step();
      check("bp_empty", {31'b0, out_valid}, 32'd0);
      out_ready = 1'b0;

      // Mid-operation reset with two entries queued.
      in_valid = 1'b1;
      in_data  = 7'h11;
      step();
      in_data  = 7'h22;
      inject_mask = 12'h001;
      step();
      check("mr_full", {31'b0, in_ready}, 32'd0);
      rst_n     = 1'b0;
      out_ready = 1'b1;
      step();
      rst_n       = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      inject_mask = '0;
      check("mr_out_valid", {31'b0, out_valid}, 32'd0);
      check("mr_in_ready", {31'b0, in_ready}, 32'd1);
      check("mr_word_count", {16'b0, word_count}, 32'd0);
      check("mr_inject_count", {16'b0, inject_count}, 32'd0);

      // Streaming: 20 back-to-back words.
      n_pops    = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_data = 7'($urandom_range(0, 127));
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      check("stream_pops", n_pops, 32'd20);
      check("stream_word_count", {16'b0, word_count}, 32'd20);
      out_ready = 1'b0;

      // Randomized traffic; the source holds its word while stalled.
      for (int i = 0; i < 400; i++) begin
         if (!(in_valid && !in_ready)) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_data     = 7'($urandom_range(0, 127));
            inject_mask = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(1, 4095)) : 12'b0;
         end
         out_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      step();
      check("rand_drained", {31'b0, out_valid}, 32'd0);

      // Counter wrap on the 4-bit instance.
      c_in_valid    = 1'b1;
      c_out_ready   = 1'b1;
      c_inject_mask = 12'h800;
      for (int i = 0; i < 17; i++) begin
         c_in_data = 7'(i);
         @(posedge clk);
         #1;
         if (i == 15) check("wrap16_word_count", {28'b0, c_word_count}, 32'd0);
      end
      c_in_valid = 1'b0;
      check("wrap_word_count", {28'b0, c_word_count}, 32'd1);
      check("wrap_inject_count", {28'b0, c_inject_count}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
